// File: rtl/msg_stream_player.sv
// Writable message buffer played out one character at a time over valid/ready,
// with a programmable inter-character gap and one-shot or loop playback.
module msg_stream_player #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned AW     = 6,
   parameter int unsigned DIV_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_mode,
   input  logic [AW:0]       msg_len,
   input  logic [DIV_W-1:0]  gap,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              wrap,
   output logic [AW-1:0]     index
);

   typedef enum logic [1:0] {StIdle, StPresent, StGap} state_e;

   localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   state_e            state_q, state_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              wrap_q, wrap_d;
   logic [AW-1:0]     index_q, index_d;
   logic [AW:0]       len_q, len_d;
   logic [DIV_W-1:0]  gap_q, gap_d;
   logic              loop_q, loop_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;

   logic              last_char;
   logic [AW-1:0]     nxt;
   logic              start_ok;

   // Buffer is not reset; a same-edge fetch of a written address sees the old data.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign last_char = ({1'b0, index_q} == (len_q - (AW+1)'(1)));
   assign nxt       = last_char ? '0 : index_q + AW'(1);
   assign start_ok  = start && (msg_len != '0) && (msg_len <= DepthW);

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      wrap_d      = 1'b0;
      index_d     = index_q;
      len_d       = len_q;
      gap_d       = gap_q;
      loop_d      = loop_q;
      cnt_d       = cnt_q;

      if (stop) begin
         out_valid_d = 1'b0;
         busy_d      = 1'b0;
         index_d     = '0;
         state_d     = StIdle;
      end else if (ena) begin
         unique case (state_q)
            StIdle: begin
               if (start_ok) begin
                  len_d       = msg_len;
                  gap_d       = gap;
                  loop_d      = loop_mode;
                  out_data_d  = mem[0];
                  index_d     = '0;
                  out_valid_d = 1'b1;
                  busy_d      = 1'b1;
                  state_d     = StPresent;
               end
            end
            StPresent: begin
               if (out_valid_q && out_ready) begin
                  if (last_char && !loop_q) begin
                     out_valid_d = 1'b0;
                     busy_d      = 1'b0;
                     done_d      = 1'b1;
                     state_d     = StIdle;
                  end else begin
                     wrap_d  = last_char;
                     index_d = nxt;
                     if (gap_q == '0) begin
                        out_data_d = mem[nxt];
                     end else begin
                        out_valid_d = 1'b0;
                        cnt_d       = gap_q;
                        state_d     = StGap;
                     end
                  end
               end
            end
            StGap: begin
               if (cnt_q == DIV_W'(1)) begin
                  out_data_d  = mem[index_q];
                  out_valid_d = 1'b1;
                  state_d     = StPresent;
               end else begin
                  cnt_d = cnt_q - DIV_W'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
         index_q     <= '0;
         len_q       <= '0;
         gap_q       <= '0;
         loop_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         wrap_q      <= wrap_d;
         index_q     <= index_d;
         len_q       <= len_d;
         gap_q       <= gap_d;
         loop_q      <= loop_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wrap      = wrap_q;
   assign index     = index_q;

endmodule

// File: tb/tb_msg_stream_player.sv
// Bench for msg_stream_player: directed scenarios plus randomized playback
// checked against a character-sequence model of the message buffer.
module tb_msg_stream_player;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 64;
   localparam int AW     = 6;
   localparam int DIV_W  = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              ena = 1'b0;
   logic              wr_en = 1'b0;
   logic [AW-1:0]     wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              loop_mode = 1'b0;
   logic [AW:0]       msg_len = '0;
   logic [DIV_W-1:0]  gap = '0;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              busy;
   logic              done;
   logic              wrap;
   logic [AW-1:0]     index;

   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W-1:0] fuego [6];
   logic [DATA_W-1:0] agua [4];
   int checks = 0;
   int passed = 0;

   msg_stream_player #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW), .DIV_W(DIV_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .stop(stop), .loop_mode(loop_mode),
      .msg_len(msg_len), .gap(gap), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done), .wrap(wrap), .index(index)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input int addr, input logic [DATA_W-1:0] data);
      wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
      step();
      wr_en = 1'b0;
      ref_mem[addr] = data;
   endtask

   task automatic begin_msg(input int len, input int g, input bit lp);
      msg_len = (AW+1)'(len); gap = DIV_W'(g); loop_mode = lp;
      ena = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Plays one message with random ena/out_ready; the expected stream is mem[k % len].
   task automatic run_msg(input int len, input int g, input bit lp, input int target);
      int acc, low, cyc, exp_idx, prev_index;
      bit hs, last, prev_valid;
      logic [DATA_W-1:0] prev_data;
      acc = 0; low = 0; cyc = 0;
      begin_msg(len, g, lp);
      checks++;
      if ({out_valid, busy, out_data, index} !== {2'b11, ref_mem[0], AW'(0)})
         $display("FAIL start_present: got %h want %h", {out_valid, busy, out_data, index},
                  {2'b11, ref_mem[0], AW'(0)});
      else passed++;
      while (acc < target && cyc < 5000) begin
         ena = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         msg_len = (AW+1)'($urandom);
         gap = DIV_W'($urandom);
         loop_mode = $urandom % 2;
         hs = out_valid && out_ready && ena;
         last = 1'b0;
         if (hs) begin
            exp_idx = acc % len;
            last = (exp_idx == len - 1);
            checks++;
            if ({out_data, index} !== {ref_mem[exp_idx], AW'(exp_idx)})
               $display("FAIL char_%0d: got data %h idx %0d want data %h idx %0d", acc,
                        out_data, index, ref_mem[exp_idx], exp_idx);
            else passed++;
            acc++;
         end
         if (!out_valid && busy && ena) low++;
         prev_valid = out_valid; prev_data = out_data; prev_index = int'(index);
         step();
         cyc++;
         if (hs) begin
            low = 0;
            checks++;
            if (last && !lp) begin
               if ({done, busy, out_valid, wrap} !== 4'b1000)
                  $display("FAIL done_pulse: got dbvw %b want 1000", {done, busy, out_valid, wrap});
               else passed++;
            end else if ({done, wrap, busy, out_valid} !== {1'b0, last, 1'b1, g == 0})
               $display("FAIL after_hs: got dwbv %b want %b", {done, wrap, busy, out_valid},
                        {1'b0, last, 1'b1, g == 0});
            else passed++;
         end else begin
            checks++;
            if ({done, wrap, busy} !== 3'b001)
               $display("FAIL idle_cycle: got dwb %b want 001", {done, wrap, busy});
            else passed++;
            if (prev_valid) begin
               checks++;
               if ({out_valid, out_data, int'(index)} !== {1'b1, prev_data, prev_index})
                  $display("FAIL hold: got v %b data %h idx %0d want v 1 data %h idx %0d",
                           out_valid, out_data, index, prev_data, prev_index);
               else passed++;
            end
         end
         if (!prev_valid && out_valid) begin
            checks++;
            if (low !== g) $display("FAIL gap_len: got %0d want %0d", low, g);
            else passed++;
         end
      end
      checks++;
      if (acc < target) $display("FAIL timeout: got %0d chars want %0d", acc, target);
      else passed++;
      ena = 1'b1; out_ready = 1'b1;
      if (lp) begin
         stop = 1'b1;
         step();
         stop = 1'b0;
         checks++;
         if ({out_valid, busy, index, done, wrap} !== '0)
            $display("FAIL loop_stop: got %h want 0", {out_valid, busy, index, done, wrap});
         else passed++;
      end
      step();
      checks++;
      if ({done, wrap, busy, out_valid} !== 4'b0000)
         $display("FAIL end_quiet: got %b want 0000", {done, wrap, busy, out_valid});
      else passed++;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_data, out_valid, busy, done, wrap, index} !== '0)
         $display("FAIL reset_async: got %h want 0", {out_data, out_valid, busy, done, wrap, index});
      else passed++;
      step(); step();
      rst_n = 1'b1;
      step();
      checks++;
      if ({out_data, out_valid, busy, done, wrap, index} !== '0)
         $display("FAIL reset_release: got %h want 0", {out_data, out_valid, busy, done, wrap, index});
      else passed++;
   endtask

   task automatic test_oneshot();
      for (int i = 0; i < 6; i++) write(i, fuego[i]);
      out_ready = 1'b1;
      begin_msg(6, 0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if ({out_valid, busy, out_data, index} !== {2'b11, fuego[k], AW'(k)})
            $display("FAIL oneshot_%0d: got %h want %h", k, {out_valid, busy, out_data, index},
                     {2'b11, fuego[k], AW'(k)});
         else passed++;
         step();
      end
      checks++;
      if ({done, busy, out_valid} !== 3'b100)
         $display("FAIL oneshot_done: got dbv %b want 100", {done, busy, out_valid});
      else passed++;
      step();
      checks++;
      if ({done, out_valid} !== 2'b00)
         $display("FAIL oneshot_after: got dv %b want 00", {done, out_valid});
      else passed++;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      begin_msg(6, 0, 1'b0);
      step(); step();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         checks++;
         if ({out_valid, out_data, index} !== {1'b1, 8'h65, AW'(2)})
            $display("FAIL bp_hold_%0d: got %h want %h", c, {out_valid, out_data, index},
                     {1'b1, 8'h65, AW'(2)});
         else passed++;
      end
      out_ready = 1'b1;
      for (int k = 2; k < 6; k++) begin
         checks++;
         if ({out_valid, out_data, index} !== {1'b1, fuego[k], AW'(k)})
            $display("FAIL bp_resume_%0d: got %h want %h", k, {out_valid, out_data, index},
                     {1'b1, fuego[k], AW'(k)});
         else passed++;
         step();
      end
      checks++;
      if ({done, busy} !== 2'b10) $display("FAIL bp_done: got db %b want 10", {done, busy});
      else passed++;
      step();
   endtask

   task automatic test_abort_illegal();
      out_ready = 1'b1;
      begin_msg(6, 0, 1'b0);
      step(); step(); step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++;
      if ({out_valid, busy, index, done, wrap} !== '0)
         $display("FAIL abort: got %h want 0", {out_valid, busy, index, done, wrap});
      else passed++;
      step();
      checks++;
      if ({done, busy} !== 2'b00) $display("FAIL abort_no_done: got db %b want 00", {done, busy});
      else passed++;
      // stop outranks start
      msg_len = 7'd6; start = 1'b1; stop = 1'b1;
      step();
      stop = 1'b0; start = 1'b0;
      checks++;
      if ({busy, out_valid} !== 2'b00) $display("FAIL stop_vs_start: got %b want 00", {busy, out_valid});
      else passed++;
      msg_len = 7'd0; start = 1'b1;
      step(); step();
      checks++;
      if ({busy, out_valid} !== 2'b00) $display("FAIL len_zero: got %b want 00", {busy, out_valid});
      else passed++;
      msg_len = 7'(DEPTH + 1);
      step(); step();
      checks++;
      if ({busy, out_valid} !== 2'b00) $display("FAIL len_over: got %b want 00", {busy, out_valid});
      else passed++;
      msg_len = 7'd6; ena = 1'b0;
      step(); step();
      checks++;
      if ({busy, out_valid} !== 2'b00) $display("FAIL start_no_ena: got %b want 00", {busy, out_valid});
      else passed++;
      start = 1'b0; ena = 1'b1;
   endtask

   task automatic test_start_busy();
      out_ready = 1'b0;
      begin_msg(6, 0, 1'b0);
      start = 1'b1; msg_len = 7'd3; gap = 8'd4; loop_mode = 1'b1;
      for (int c = 0; c < 4; c++) step();
      checks++;
      if ({busy, out_valid, out_data, index} !== {2'b11, fuego[0], AW'(0)})
         $display("FAIL busy_restart: got %h want %h", {busy, out_valid, out_data, index},
                  {2'b11, fuego[0], AW'(0)});
      else passed++;
      start = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) step();
      checks++;
      if ({done, busy, wrap} !== 3'b100)
         $display("FAIL shadow_len: got dbw %b want 100", {done, busy, wrap});
      else passed++;
      step();
   endtask

   task automatic test_loop();
      for (int i = 0; i < 4; i++) write(i, agua[i]);
      run_msg(4, 0, 1'b1, 10);
   endtask

   task automatic test_random();
      int len, g;
      bit lp;
      for (int m = 0; m < 8; m++) begin
         len = (m == 0) ? 1 : (m == 1) ? DEPTH : $urandom_range(2, 12);
         g = $urandom_range(0, 3);
         lp = (m == 0) ? 1'b1 : 1'($urandom % 2);
         for (int i = 0; i < len; i++) write(i, DATA_W'($urandom));
         run_msg(len, g, lp, lp ? 2 * len + 1 : len);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 6; i++) write(i, fuego[i]);
      out_ready = 1'b1;
      begin_msg(6, 5, 1'b0);
      step();
      checks++;
      if ({busy, out_valid} !== 2'b10) $display("FAIL in_gap: got %b want 10", {busy, out_valid});
      else passed++;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_data, out_valid, busy, done, wrap, index} !== '0)
         $display("FAIL reset_mid: got %h want 0", {out_data, out_valid, busy, done, wrap, index});
      else passed++;
      #1 rst_n = 1'b1;
      step();
      run_msg(6, 0, 1'b0, 6);
   endtask

   initial begin
      fuego = '{8'h46, 8'h75, 8'h65, 8'h67, 8'h6F, 8'h20};
      agua  = '{8'h41, 8'h67, 8'h75, 8'h61};
      test_reset();
      test_oneshot();
      test_backpressure();
      run_msg(6, 3, 1'b0, 6);
      test_abort_illegal();
      test_start_busy();
      test_loop();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
